fft8_frame_ctrl: RTL and testbench

- Sequencer wrapping the combinational fp16 8-point FFT/IFFT core (`fft_8point`).
- Accepts a serial stream of complex fp16 samples, one per handshake, and assembles 8-sample frames.
- Presents each frame in parallel to the core, waits a settle interval, then captures the results and streams them out serially with valid/ready.
- Sits between the sample-stream fabric and the core; only this block drives the core's inputs.

---
 rtl/fft8_frame_ctrl_pkg.sv | 16 +
 rtl/fft8_frame_ctrl_if.sv | 35 +++
 rtl/fft8_frame_ctrl_sample_buf.sv | 37 +++
 rtl/fft8_frame_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fft8_frame_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft8_frame_ctrl_pkg.sv
// Shared constants and state type for the fp16 8-point FFT frame sequencer.
package fft8_ctrl_pkg;

  localparam int N_PTS = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [15:0] FP16_ZERO = 16'h0000;

endpackage

// File: rtl/fft8_frame_ctrl_if.sv
// Sample-stream interface of the FFT frame sequencer: serial input samples in,
// serial result samples out, both with valid/ready handshakes.
interface fft8_frame_ctrl_if
  import fft8_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              in_mode;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              out_err;

  // sequencer side
  modport slave (
    input  in_valid, in_re, in_im, in_mode, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last, out_err
  );

  // fabric side: sample source and result sink
  modport master (
    output in_valid, in_re, in_im, in_mode, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last, out_err
  );

endinterface

// File: rtl/fft8_frame_ctrl_sample_buf.sv
// 8-entry register file: one indexed write port, a whole-buffer parallel load
// port (load wins over write), and every entry visible on a flat read bus.
module fft8_sample_buf
  import fft8_ctrl_pkg::*;
#(
  parameter int ENTRY_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [IDX_W-1:0]         waddr,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic                     ld_en,
  input  logic [N_PTS*ENTRY_W-1:0] ld_data,
  output logic [N_PTS*ENTRY_W-1:0] rd_bus
);

  logic [ENTRY_W-1:0] mem [N_PTS];

  // storage: reset clear, parallel load, or single-entry write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_PTS; k++) mem[k] <= '0;
    end else if (ld_en) begin
      for (int unsigned k = 0; k < N_PTS; k++) mem[k] <= ld_data[k*ENTRY_W +: ENTRY_W];
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // flatten all entries onto the read bus, entry k at [k*ENTRY_W +: ENTRY_W]
  always_comb begin
    rd_bus = '0;
    for (int unsigned k = 0; k < N_PTS; k++) rd_bus[k*ENTRY_W +: ENTRY_W] = mem[k];
  end

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer around the combinational fp16 8-point FFT/IFFT core.
// Collects 8 serial samples, holds them on the core for SETTLE_CYC cycles,
// captures the results and streams them out serially.
// Optional build macro FFT8_ERR_CNT_EN adds err_cnt/err_cnt_clr, a saturating
// count of frames the core flagged invalid.
module fft8_frame_ctrl
  import fft8_ctrl_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  fft8_frame_ctrl_if.slave        s,
  output logic                    busy,
  output logic                    core_mode,
  output logic [N_PTS*DATA_W-1:0] core_re_in,
  output logic [N_PTS*DATA_W-1:0] core_im_in,
  input  logic [N_PTS*DATA_W-1:0] core_re_out,
  input  logic [N_PTS*DATA_W-1:0] core_im_out,
  input  logic                    core_invalid
`ifdef FFT8_ERR_CNT_EN
  ,
  input  logic                    err_cnt_clr,
  output logic [15:0]             err_cnt
`endif
);

  localparam int               ENTRY_W     = 2 * DATA_W;
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_PTS - 1);

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         cnt, cnt_nxt;
  logic [IDX_W-1:0]         out_idx, idx_nxt;
  logic [3:0]               settle_cnt, settle_nxt;
  logic                     mode_nxt;
  logic                     frame_err, err_nxt;
  logic                     in_we, res_ld;
  logic [N_PTS*ENTRY_W-1:0] in_bus, res_bus, cap_data;
  logic [ENTRY_W-1:0]       res_word;

  // entries are packed {re, im}
  fft8_sample_buf #(.ENTRY_W(ENTRY_W)) u_in_buf (
    .clk    (clk),
    .rst    (rst),
    .we     (in_we),
    .waddr  (cnt),
    .wdata  ({s.in_re, s.in_im}),
    .ld_en  (1'b0),
    .ld_data('0),
    .rd_bus (in_bus)
  );

  fft8_sample_buf #(.ENTRY_W(ENTRY_W)) u_res_buf (
    .clk    (clk),
    .rst    (rst),
    .we     (1'b0),
    .waddr  ('0),
    .wdata  ('0),
    .ld_en  (res_ld),
    .ld_data(cap_data),
    .rd_bus (res_bus)
  );

  // FSM state and frame bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      cnt        <= '0;
      settle_cnt <= '0;
      out_idx    <= '0;
      core_mode  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      settle_cnt <= settle_nxt;
      out_idx    <= idx_nxt;
      core_mode  <= mode_nxt;
      frame_err  <= err_nxt;
    end
  end

  // next-state decode: load samples, settle the core, capture once, drain
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    settle_nxt = settle_cnt;
    idx_nxt    = out_idx;
    mode_nxt   = core_mode;
    err_nxt    = frame_err;
    in_we      = 1'b0;
    res_ld     = 1'b0;
    case (state)
      LOAD: begin
        if (s.in_valid) begin
          in_we   = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == '0) mode_nxt = s.in_mode;
          if (cnt == LAST_IDX) begin
            state_nxt  = SETTLE;
            settle_nxt = '0;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = CAPTURE;
        else                           settle_nxt = settle_cnt + 1'b1;
      end
      CAPTURE: begin
        res_ld    = 1'b1;
        err_nxt   = core_invalid;
        idx_nxt   = '0;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        if (s.out_ready) begin
          idx_nxt = out_idx + 1'b1;
          if (out_idx == LAST_IDX) state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // capture data: core results, or fp16 zeros when the core flags the frame
  always_comb begin
    cap_data = '0;
    for (int unsigned k = 0; k < N_PTS; k++) begin
      if (core_invalid)
        cap_data[k*ENTRY_W +: ENTRY_W] = {2{DATA_W'(FP16_ZERO)}};
      else
        cap_data[k*ENTRY_W +: ENTRY_W] = {core_re_out[k*DATA_W +: DATA_W],
                                          core_im_out[k*DATA_W +: DATA_W]};
    end
  end

  // core inputs come straight from the input buffer registers
  always_comb begin
    core_re_in = '0;
    core_im_in = '0;
    for (int unsigned k = 0; k < N_PTS; k++) begin
      core_re_in[k*DATA_W +: DATA_W] = in_bus[k*ENTRY_W + DATA_W +: DATA_W];
      core_im_in[k*DATA_W +: DATA_W] = in_bus[k*ENTRY_W +: DATA_W];
    end
  end

  assign res_word = res_bus[out_idx*ENTRY_W +: ENTRY_W];

  // stream-side outputs; result data is only presented while draining
  always_comb begin
    s.in_ready  = (state == LOAD);
    s.out_valid = (state == DRAIN);
    s.out_idx   = out_idx;
    s.out_re    = '0;
    s.out_im    = '0;
    s.out_last  = 1'b0;
    s.out_err   = 1'b0;
    if (state == DRAIN) begin
      s.out_re   = res_word[ENTRY_W-1 -: DATA_W];
      s.out_im   = res_word[DATA_W-1:0];
      s.out_last = (out_idx == LAST_IDX);
      s.out_err  = frame_err;
    end
    busy = (state != LOAD) || (cnt != '0);
  end

`ifdef FFT8_ERR_CNT_EN
  // saturating count of invalid frames; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || err_cnt_clr) begin
      err_cnt <= '0;
    end else if (state == CAPTURE && core_invalid && err_cnt != '1) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Bench for fft8_frame_ctrl. A stand-in core (impulse and known-vector lookups,
// otherwise a deterministic mixing function, invalid on any inf/NaN input word)
// drives the core ports; expected outputs come from frame-level reasoning.
module tb_fft8_frame_ctrl;

  localparam int DATA_W     = 16;
  localparam int SETTLE_CYC = 2;

  // packed frames: element [k] is sample k, so concatenations list index 7 first
  localparam logic [7:0][15:0] IMP_RE = {{7{16'h0000}}, 16'h3C00};
  localparam logic [7:0][15:0] IMP_ORE = {8{16'h3C00}};
  localparam logic [7:0][15:0] KV_RE  = {16'h39a8, 16'h39a8, 16'h39a8, 16'h39a8,
                                         16'h0000, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [7:0][15:0] KV_IM  = {16'h39a8, 16'h39a8, 16'h0000, 16'h0000,
                                         16'h39a8, 16'h39a8, 16'h0000, 16'h0000};
  localparam logic [7:0][15:0] KV_ORE = {16'hb9a8, 16'h3da8, 16'hb9a8, 16'h0000,
                                         16'hb9a8, 16'hbda8, 16'hb9a8, 16'h41a8};
  localparam logic [7:0][15:0] KV_OIM = {16'hbed3, 16'hbda8, 16'hb4ae, 16'h0000,
                                         16'h34ae, 16'hbda8, 16'h3ed3, 16'h41a8};

  typedef struct packed {
    logic [7:0][15:0] re;
    logic [7:0][15:0] im;
    logic             mode;
    logic             flip;
    logic [1:0]       bp;
    logic [7:0][15:0] exp_re;
    logic [7:0][15:0] exp_im;
    logic             exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft8_frame_ctrl_if #(.DATA_W(DATA_W)) bus ();

  logic             busy;
  logic             core_mode;
  logic [7:0][15:0] core_re_in, core_im_in, core_re_out, core_im_out;
  logic             core_invalid;
`ifdef FFT8_ERR_CNT_EN
  logic [15:0]      err_cnt;
  logic             err_cnt_clr = 1'b0;
  int               exp_ec = 0;
`endif

  int total = 0;
  int bad   = 0;

  fft8_frame_ctrl #(.DATA_W(DATA_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (bus),
    .busy        (busy),
    .core_mode   (core_mode),
    .core_re_in  (core_re_in),
    .core_im_in  (core_im_in),
    .core_re_out (core_re_out),
    .core_im_out (core_im_out),
    .core_invalid(core_invalid)
`ifdef FFT8_ERR_CNT_EN
    ,
    .err_cnt_clr (err_cnt_clr),
    .err_cnt     (err_cnt)
`endif
  );

  function automatic logic core_inv_fn(input logic [7:0][15:0] re, input logic [7:0][15:0] im);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 8; k++)
      if (re[k][14:10] == 5'h1F || im[k][14:10] == 5'h1F) r = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0][15:0] core_re_fn(input logic [7:0][15:0] re,
                                                  input logic [7:0][15:0] im, input logic mode);
    logic [7:0][15:0] r;
    if (core_inv_fn(re, im)) return {8{16'h7E00}};
    if (!mode && re == IMP_RE && im == '0) return IMP_ORE;
    if (!mode && re == KV_RE && im == KV_IM) return KV_ORE;
    for (int k = 0; k < 8; k++)
      r[k] = re[k] ^ {im[7-k][7:0], im[7-k][15:8]} ^ (mode ? 16'hA5A5 : 16'h0000);
    return r;
  endfunction

  function automatic logic [7:0][15:0] core_im_fn(input logic [7:0][15:0] re,
                                                  input logic [7:0][15:0] im, input logic mode);
    logic [7:0][15:0] r;
    if (core_inv_fn(re, im)) return {8{16'hFE00}};
    if (!mode && re == IMP_RE && im == '0) return '0;
    if (!mode && re == KV_RE && im == KV_IM) return KV_OIM;
    for (int k = 0; k < 8; k++)
      r[k] = im[k] + re[(k+3)%8] + (mode ? 16'h0101 : 16'h0000);
    return r;
  endfunction

  // stand-in core
  always_comb begin
    core_re_out  = core_re_fn(core_re_in, core_im_in, core_mode);
    core_im_out  = core_im_fn(core_re_in, core_im_in, core_mode);
    core_invalid = core_inv_fn(core_re_in, core_im_in);
  end

  // what a whole frame must produce at the stream output
  task automatic model(input logic [7:0][15:0] re, input logic [7:0][15:0] im, input logic mode,
                       output logic [7:0][15:0] ere, output logic [7:0][15:0] eim, output logic eerr);
    eerr = core_inv_fn(re, im);
    if (eerr) begin
      ere = '0;
      eim = '0;
    end else begin
      ere = core_re_fn(re, im, mode);
      eim = core_im_fn(re, im, mode);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sends the first n samples; mode0 goes with sample 0, later samples carry
  // a random or flipped mode that must be ignored
  task automatic send_frame(input logic [7:0][15:0] re, input logic [7:0][15:0] im,
                            input logic mode0, input logic flip, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int w;
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      bus.in_valid = 1'b0;
      bus.in_re    = 16'($urandom);
      bus.in_im    = 16'($urandom);
      bus.in_mode  = 1'($urandom);
      repeat (gap) tick();
      bus.in_valid = 1'b1;
      bus.in_re    = re[i];
      bus.in_im    = im[i];
      if (i == 0)    bus.in_mode = mode0;
      else if (flip) bus.in_mode = (i >= 4) ? ~mode0 : mode0;
      else           bus.in_mode = 1'($urandom);
      w = 0;
      while (!bus.in_ready && w < 64) begin
        tick();
        w++;
      end
      chk($sformatf("in_ready_s%0d", i), bus.in_ready, 1);
      tick();
      chk($sformatf("core_mode_s%0d", i), core_mode, mode0);
      if (i == 0) chk("busy_after_s0", busy, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  // called right after the edge accepting sample 7.
  // bp: 0 always ready, 1 random ready, 2 five-cycle stall at idx 3
  task automatic drain(input logic [7:0][15:0] ere, input logic [7:0][15:0] eim,
                       input logic eerr, input logic [1:0] bp, input string tag);
    int   lat;
    int   beat;
    int   guard;
    logic rdy;
    logic stalled;
    lat = 0; beat = 0; guard = 0; stalled = 1'b0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && lat < 64) begin
      chk({tag, "_settle_in_ready"}, bus.in_ready, 0);
      tick();
      lat++;
    end
    // SETTLE_CYC settle cycles plus the capture cycle follow the accepting edge
    chk({tag, "_latency"}, lat, SETTLE_CYC + 1);
    while (beat < 8 && guard < 400) begin
      guard++;
      chk({tag, "_valid"}, bus.out_valid, 1);
      if (!bus.out_valid) break;
      chk($sformatf("%s_idx%0d", tag, beat), bus.out_idx, beat);
      chk($sformatf("%s_re%0d", tag, beat), bus.out_re, ere[beat]);
      chk($sformatf("%s_im%0d", tag, beat), bus.out_im, eim[beat]);
      chk($sformatf("%s_err%0d", tag, beat), bus.out_err, eerr);
      chk($sformatf("%s_last%0d", tag, beat), bus.out_last, (beat == 7));
      chk({tag, "_drain_in_ready"}, bus.in_ready, 0);
      if (bp == 2'd2 && beat == 3 && !stalled) begin
        stalled = 1'b1;
        bus.out_ready = 1'b0;
        repeat (5) begin
          tick();
          chk({tag, "_stall_valid"}, bus.out_valid, 1);
          chk({tag, "_stall_idx"}, bus.out_idx, 3);
          chk({tag, "_stall_re"}, bus.out_re, ere[3]);
          chk({tag, "_stall_im"}, bus.out_im, eim[3]);
          chk({tag, "_stall_in_ready"}, bus.in_ready, 0);
        end
      end
      rdy = (bp == 2'd1) ? 1'($urandom) : 1'b1;
      bus.out_ready = rdy;
      tick();
      if (rdy) beat++;
    end
    chk({tag, "_beats"}, beat, 8);
    chk({tag, "_end_valid"}, bus.out_valid, 0);
    chk({tag, "_end_idx"}, bus.out_idx, 0);
    chk({tag, "_end_in_ready"}, bus.in_ready, 1);
    chk({tag, "_end_busy"}, busy, 0);
  endtask

  vec_t tbl [5];

  initial begin
    logic [7:0][15:0] re, im, ere, eim;
    logic             eerr, mode;
    int               lat, seen;

    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b0;

    // vector table
    tbl[0] = '{re: IMP_RE, im: '0, mode: 1'b0, flip: 1'b0, bp: 2'd0,
               exp_re: IMP_ORE, exp_im: '0, exp_err: 1'b0};
    tbl[1] = '{re: KV_RE, im: KV_IM, mode: 1'b0, flip: 1'b0, bp: 2'd1,
               exp_re: KV_ORE, exp_im: KV_OIM, exp_err: 1'b0};
    re = KV_RE;
    re[0] = 16'h7C00;
    tbl[2] = '{re: re, im: KV_IM, mode: 1'b0, flip: 1'b0, bp: 2'd0,
               exp_re: '0, exp_im: '0, exp_err: 1'b1};
    model(KV_RE, KV_IM, 1'b1, ere, eim, eerr);
    tbl[3] = '{re: KV_RE, im: KV_IM, mode: 1'b1, flip: 1'b1, bp: 2'd2,
               exp_re: ere, exp_im: eim, exp_err: eerr};
    for (int k = 0; k < 8; k++) begin
      re[k] = 16'($urandom) & 16'hBBFF;
      im[k] = 16'($urandom) & 16'hBBFF;
    end
    model(re, im, 1'b0, ere, eim, eerr);
    tbl[4] = '{re: re, im: im, mode: 1'b0, flip: 1'b0, bp: 2'd1,
               exp_re: ere, exp_im: eim, exp_err: eerr};

    // reset values
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_re", bus.out_re, 0);
    chk("rst_out_im", bus.out_im, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_core_mode", core_mode, 0);
    chk("rst_core_re_in", |core_re_in, 0);
    chk("rst_core_im_in", |core_im_in, 0);
`ifdef FFT8_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // directed vectors
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].re, tbl[i].im, tbl[i].mode, tbl[i].flip, 8, 0);
      drain(tbl[i].exp_re, tbl[i].exp_im, tbl[i].exp_err, tbl[i].bp, $sformatf("vec%0d", i));
`ifdef FFT8_ERR_CNT_EN
      if (tbl[i].exp_err) exp_ec++;
      chk($sformatf("err_cnt_vec%0d", i), err_cnt, exp_ec);
`endif
    end
`ifdef FFT8_ERR_CNT_EN
    err_cnt_clr = 1'b1;
    tick();
    err_cnt_clr = 1'b0;
    chk("err_cnt_clr", err_cnt, 0);
`endif

    // random frames with input gaps and output backpressure
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 8; k++) begin
        re[k] = 16'($urandom);
        im[k] = 16'($urandom);
      end
      mode = 1'($urandom);
      model(re, im, mode, ere, eim, eerr);
      send_frame(re, im, mode, 1'b0, 8, 3);
      drain(ere, eim, eerr, 2'd1, $sformatf("rnd%0d", f));
    end

    // reset after 5 accepted samples discards the partial frame
    send_frame(KV_RE, KV_IM, 1'b1, 1'b0, 5, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstload_in_ready", bus.in_ready, 1);
    chk("rstload_busy", busy, 0);
    chk("rstload_out_valid", bus.out_valid, 0);
    chk("rstload_core_mode", core_mode, 0);
    chk("rstload_core_re_in", |core_re_in, 0);
    send_frame(KV_RE, KV_IM, 1'b0, 1'b0, 8, 0);
    drain(KV_ORE, KV_OIM, 1'b0, 2'd0, "after_rstload");

    // reset during drain at idx 2 drops the remaining beats
    send_frame(IMP_RE, '0, 1'b0, 1'b0, 8, 0);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      tick();
      lat++;
    end
    chk("rstdrain_latency", lat, SETTLE_CYC + 1);
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rstdrain_idx", bus.out_idx, 2);
    chk("rstdrain_re", bus.out_re, 16'h3C00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      if (bus.out_valid) seen++;
      tick();
    end
    chk("rstdrain_no_valid", seen, 0);
    chk("rstdrain_in_ready", bus.in_ready, 1);
    chk("rstdrain_busy", busy, 0);
    send_frame(IMP_RE, '0, 1'b0, 1'b0, 8, 0);
    drain(IMP_ORE, '0, 1'b0, 2'd0, "after_rstdrain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
